// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned SEL_W           = 4;
   localparam int unsigned STALL_W         = 6;
   localparam int unsigned STALL_IF        = 1;
   localparam int unsigned STALL_MEM       = 4;
   localparam int unsigned ACK_TIMEOUT_DEF = 255;
   localparam int unsigned CNT_W_DEF       = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2
   } state_e;

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_cmd_t;

   // Instruction fetches are always full-word reads.
   function automatic bus_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
      bus_cmd_t cmd;
      cmd.we    = 1'b0;
      cmd.sel   = {SEL_W{1'b1}};
      cmd.addr  = addr;
      cmd.wdata = '0;
      return cmd;
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts bus cycles without acknowledge and flags the cycle the limit is hit.
module bus_timeout_counter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   input  logic ack,
   output logic expired_c
);

   logic [CNT_W-1:0] cnt_q;

   // Fires during the last permitted wait cycle so the owner is released at that edge.
   assign expired_c = run & ~ack & (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear || ack || expired_c) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access,
// buffering results until the owning stage advances.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               if_ce_i,
   input  logic [ADDR_W-1:0]  if_addr_i,
   output logic [DATA_W-1:0]  if_data_o,
   output logic               stallreq_if_o,
   input  logic               mem_ce_i,
   input  logic               mem_we_i,
   input  logic [SEL_W-1:0]   mem_sel_i,
   input  logic [ADDR_W-1:0]  mem_addr_i,
   input  logic [DATA_W-1:0]  mem_data_i,
   output logic [DATA_W-1:0]  mem_data_o,
   output logic               stallreq_mem_o,
   output logic               bus_req_o,
   output logic               bus_we_o,
   output logic [SEL_W-1:0]   bus_sel_o,
   output logic [ADDR_W-1:0]  bus_addr_o,
   output logic [DATA_W-1:0]  bus_wdata_o,
   input  logic [DATA_W-1:0]  bus_rdata_i,
   input  logic               bus_ack_i,
   output logic               bus_err_o
);

   state_e            state_q, state_d;
   bus_cmd_t          cmd_q, cmd_d;
   logic              req_q, req_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic              if_drop_q, if_drop_d;
   logic              mem_drop_q, mem_drop_d;
   logic              busy;
   logic              expired_c;
   logic              complete;
   logic [DATA_W-1:0] rdata_c;
   logic              unused_stall;

   assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

   assign busy     = (state_q != ST_IDLE);
   assign complete = busy & (bus_ack_i | expired_c);
   assign rdata_c  = bus_ack_i ? bus_rdata_i : '0;

   bus_timeout_counter #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .run       (busy),
      .clear     (~busy),
      .ack       (bus_ack_i),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         req_q      <= 1'b0;
         err_q      <= 1'b0;
         if_data_q  <= '0;
         mem_data_q <= '0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         if_drop_q  <= 1'b0;
         mem_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         req_q      <= req_d;
         err_q      <= err_d;
         if_data_q  <= if_data_d;
         mem_data_q <= mem_data_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
         if_drop_q  <= if_drop_d;
         mem_drop_q <= mem_drop_d;
      end
   end

   // Next-state logic; a completing capture overrides the done-flag clear.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      req_d      = req_q;
      err_d      = 1'b0;
      if_data_d  = if_data_q;
      mem_data_d = mem_data_q;
      if_done_d  = if_done_q;
      mem_done_d = mem_done_q;
      if_drop_d  = if_drop_q;
      mem_drop_d = mem_drop_q;

      if (!stall_i[STALL_MEM] || flush_i) mem_done_d = 1'b0;
      if (!stall_i[STALL_IF]  || flush_i) if_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_ce_i && !mem_done_q) begin
               state_d = ST_DATA;
               req_d   = 1'b1;
               cmd_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, wdata: mem_data_i};
            end else if (if_ce_i && !if_done_q) begin
               state_d = ST_INST;
               req_d   = 1'b1;
               cmd_d   = fetch_cmd(if_addr_i);
            end
         end
         ST_DATA: begin
            if (complete) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               cmd_d   = '0;
               err_d   = expired_c;
               if (mem_drop_q || flush_i) begin
                  mem_drop_d = 1'b0;
               end else begin
                  mem_data_d = rdata_c;
                  mem_done_d = 1'b1;
               end
            end else if (flush_i) begin
               mem_drop_d = 1'b1;
            end
         end
         ST_INST: begin
            if (complete) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               cmd_d   = '0;
               err_d   = expired_c;
               if (if_drop_q || flush_i) begin
                  if_drop_d = 1'b0;
               end else begin
                  if_data_d = rdata_c;
                  if_done_d = 1'b1;
               end
            end else if (flush_i) begin
               if_drop_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            cmd_d   = '0;
         end
      endcase
   end

   assign stallreq_mem_o = mem_ce_i & ~mem_done_q;
   assign stallreq_if_o  = if_ce_i & ~if_done_q & ~flush_i;

   assign bus_req_o   = req_q;
   assign bus_we_o    = cmd_q.we;
   assign bus_sel_o   = cmd_q.sel;
   assign bus_addr_o  = cmd_q.addr;
   assign bus_wdata_o = cmd_q.wdata;
   assign bus_err_o   = err_q;
   assign if_data_o   = if_data_q;
   assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int unsigned TO = 8;

   logic        clk;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        stallreq_if_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        stallreq_mem_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   mem_bus_arbiter #(.ACK_TIMEOUT(TO), .CNT_W(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .if_ce_i        (if_ce_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .stallreq_if_o  (stallreq_if_o),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .mem_data_o     (mem_data_o),
      .stallreq_mem_o (stallreq_mem_o),
      .bus_req_o      (bus_req_o),
      .bus_we_o       (bus_we_o),
      .bus_sel_o      (bus_sel_o),
      .bus_addr_o     (bus_addr_o),
      .bus_wdata_o    (bus_wdata_o),
      .bus_rdata_i    (bus_rdata_i),
      .bus_ack_i      (bus_ack_i),
      .bus_err_o      (bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference: requester 0 = data, 1 = fetch, owner -1 = bus free.
   int          m_owner;
   int          m_age;
   bit          m_done [2];
   bit          m_drop [2];
   logic [31:0] m_dout [2];
   bit          m_err;
   bit          m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   int          sbit [2] = '{4, 1};

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_err   = 1'b0;
      for (int r = 0; r < 2; r++) begin
         m_done[r] = 1'b0;
         m_drop[r] = 1'b0;
         m_dout[r] = 32'h0;
      end
   endtask

   task automatic model_step();
      bit nd [2];
      nd    = m_done;
      m_err = 1'b0;
      for (int r = 0; r < 2; r++)
         if (!stall_i[sbit[r]] || flush_i) nd[r] = 1'b0;
      if (m_owner >= 0) begin
         if (bus_ack_i || m_age == int'(TO)) begin
            m_err = !bus_ack_i;
            if (m_drop[m_owner] || flush_i) begin
               m_drop[m_owner] = 1'b0;
            end else begin
               m_dout[m_owner] = bus_ack_i ? bus_rdata_i : 32'h0;
               nd[m_owner]     = 1'b1;
            end
            m_owner = -1;
         end else begin
            m_age++;
            if (flush_i) m_drop[m_owner] = 1'b1;
         end
      end else if (mem_ce_i && !m_done[0]) begin
         m_owner = 0; m_age = 1;
         m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_data_i;
      end else if (if_ce_i && !m_done[1]) begin
         m_owner = 1; m_age = 1;
         m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr_i; m_wdata = 32'h0;
      end
      m_done = nd;
   endtask

   initial begin
      rst = 1'b1; stall_i = '0; flush_i = 1'b0;
      if_ce_i = 1'b0; if_addr_i = '0;
      mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
      bus_rdata_i = '0; bus_ack_i = 1'b0;
      tick(); tick();
      chk("rst_req", bus_req_o, 0);
      chk("rst_addr", bus_addr_o, 0);
      chk("rst_if_data", if_data_o, 0);
      chk("rst_mem_data", mem_data_o, 0);
      chk("rst_err", bus_err_o, 0);
      rst = 1'b0;
      tick();

      // Instruction fetch with ack three cycles after request
      if_ce_i = 1'b1; if_addr_i = 32'h100; stall_i = 6'b000010;
      tick();
      chk("if_req", bus_req_o, 1);
      chk("if_addr", bus_addr_o, 32'h100);
      chk("if_sel", bus_sel_o, 4'hF);
      chk("if_we", bus_we_o, 0);
      tick(); tick();
      chk("if_req_hold", bus_req_o, 1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h3C011234;
      tick();
      bus_ack_i = 1'b0;
      chk("if_req_drop", bus_req_o, 0);
      chk("if_data", if_data_o, 32'h3C011234);
      chk("if_stallreq_fall", stallreq_if_o, 0);
      if_ce_i = 1'b0; stall_i = '0;
      tick();

      // Simultaneous requests: store issued first
      stall_i = 6'b010010;
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
      mem_addr_i = 32'h80; mem_data_i = 32'hDEADBEEF;
      if_ce_i = 1'b1; if_addr_i = 32'h200;
      tick();
      chk("st_we", bus_we_o, 1);
      chk("st_addr", bus_addr_o, 32'h80);
      chk("st_wdata", bus_wdata_o, 32'hDEADBEEF);
      chk("st_sel", bus_sel_o, 4'b0011);
      chk("st_if_stall", stallreq_if_o, 1);
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      chk("st_gap_req", bus_req_o, 0);
      chk("st_mem_stall", stallreq_mem_o, 0);
      chk("st_if_stall2", stallreq_if_o, 1);
      tick();
      chk("if2_req", bus_req_o, 1);
      chk("if2_addr", bus_addr_o, 32'h200);
      chk("if2_we", bus_we_o, 0);
      chk("if2_if_stall", stallreq_if_o, 1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA5555;
      tick();
      bus_ack_i = 1'b0;
      chk("if2_data", if_data_o, 32'hAAAA5555);
      mem_ce_i = 1'b0; if_ce_i = 1'b0; stall_i = '0;
      tick();

      // Load completes while MEM stays stalled
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h40;
      stall_i = 6'b010000;
      tick();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h000000FF;
      tick();
      bus_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("ld_hold_data", mem_data_o, 32'hFF);
         chk("ld_hold_stall", stallreq_mem_o, 0);
         if (i < 3) tick();
      end
      stall_i = '0;
      tick();
      chk("ld_done_clear", stallreq_mem_o, 1);
      mem_ce_i = 1'b0;
      tick();

      // Flush during fetch: result discarded, bus cycle still completes
      if_ce_i = 1'b1; if_addr_i = 32'h300; stall_i = 6'b000010;
      tick();
      flush_i = 1'b1;
      tick();
      chk("fl_stall_mask", stallreq_if_o, 0);
      flush_i = 1'b0;
      chk("fl_req_kept", bus_req_o, 1);
      tick();
      chk("fl_req_kept2", bus_req_o, 1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
      tick();
      bus_ack_i = 1'b0;
      chk("fl_req_drop", bus_req_o, 0);
      chk("fl_data_kept", if_data_o, 32'hAAAA5555);
      chk("fl_not_done", stallreq_if_o, 1);
      if_ce_i = 1'b0; stall_i = '0;
      tick();

      // Timeout: no ack ever arrives
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500; stall_i = 6'b010000;
      tick();
      for (int i = 0; i < int'(TO); i++) begin
         chk("to_req_high", bus_req_o, 1);
         chk("to_err_low", bus_err_o, 0);
         tick();
      end
      chk("to_req_low", bus_req_o, 0);
      chk("to_err_pulse", bus_err_o, 1);
      chk("to_data_zero", mem_data_o, 0);
      chk("to_stall_fall", stallreq_mem_o, 0);
      tick();
      chk("to_err_once", bus_err_o, 0);
      mem_ce_i = 1'b0; stall_i = '0;
      tick();

      // Ack while idle is ignored
      bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA55AA;
      tick();
      bus_ack_i = 1'b0;
      chk("idle_ack_mem", mem_data_o, 0);
      chk("idle_ack_if", if_data_o, 32'hAAAA5555);
      chk("idle_ack_req", bus_req_o, 0);

      // Reset in the middle of a data cycle
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h600; mem_data_i = 32'h1111; stall_i = 6'b010000;
      tick(); tick();
      chk("rm_busy", bus_req_o, 1);
      rst = 1'b1; mem_ce_i = 1'b0; stall_i = '0;
      tick();
      chk("rm_req", bus_req_o, 0);
      chk("rm_we", bus_we_o, 0);
      chk("rm_addr", bus_addr_o, 0);
      chk("rm_wdata", bus_wdata_o, 0);
      chk("rm_if_data", if_data_o, 0);
      chk("rm_stall", stallreq_mem_o, 0);
      rst = 1'b0;
      tick();

      // Randomized traffic against the reference model
      model_reset();
      for (int c = 0; c < 2500; c++) begin
         mem_ce_i    = ($urandom_range(0, 1) == 0);
         mem_we_i    = $urandom_range(0, 1) != 0;
         mem_sel_i   = 4'($urandom);
         mem_addr_i  = $urandom;
         mem_data_i  = $urandom;
         if_ce_i     = ($urandom_range(0, 2) != 0);
         if_addr_i   = $urandom;
         stall_i     = 6'($urandom);
         flush_i     = ($urandom_range(0, 15) == 0);
         bus_rdata_i = $urandom;
         bus_ack_i   = (m_owner >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         model_step();
         tick();
         chk("r_req", bus_req_o, (m_owner >= 0) ? 1 : 0);
         chk("r_err", bus_err_o, m_err);
         chk("r_mem_data", mem_data_o, m_dout[0]);
         chk("r_if_data", if_data_o, m_dout[1]);
         chk("r_stall_mem", stallreq_mem_o, mem_ce_i & ~m_done[0]);
         chk("r_stall_if", stallreq_if_o, if_ce_i & ~m_done[1] & ~flush_i);
         if (m_owner >= 0) begin
            chk("r_we", bus_we_o, m_we);
            chk("r_sel", bus_sel_o, m_sel);
            chk("r_addr", bus_addr_o, m_addr);
            if (m_owner == 0) chk("r_wdata", bus_wdata_o, m_wdata);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
